// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access size codes and byte-lane helpers shared by dmem_arb and the LSU
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  function automatic logic [3:0] gen_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      SZ_WORD: return off == 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ld_align.sv
// rtl/dmem_ld_align.sv - shifts a memory word down to the accessed lane and extends it
module dmem_ld_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] sh;

  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: result = {{16{~uns & sh[15]}}, sh[15:0]};
      SZ_WORD: result = sh;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - round-robin two-port arbiter and access sequencer in front of dmem
module dmem_arb
  import dmem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_p0_req,
  output logic          o_p0_gnt,
  input  logic          i_p0_we,
  input  logic [1:0]    i_p0_size,
  input  logic          i_p0_uns,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [31:0]   i_p0_wdata,
  output logic          o_p0_rvalid,
  output logic [31:0]   o_p0_rdata,
  output logic          o_p0_err,
  input  logic          i_p1_req,
  output logic          o_p1_gnt,
  input  logic          i_p1_we,
  input  logic [1:0]    i_p1_size,
  input  logic          i_p1_uns,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [31:0]   i_p1_wdata,
  output logic          o_p1_rvalid,
  output logic [31:0]   o_p1_rdata,
  output logic          o_p1_err,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_mask,
  output logic [7:0]    o_mem_addr,
  output logic [31:0]   o_mem_data,
  input  logic [31:0]   i_mem_data
);

  logic          last;
  logic          accept;
  logic          sel;
  logic          s_we;
  logic [1:0]    s_size;
  logic          s_uns;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [1:0]    s_off;
  logic          s_legal;

  logic          r_valid;
  logic          r_port;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [1:0]    r_off;
  logic          r_err;
  logic          resp;
  logic [31:0]   ld_res;
  logic [31:0]   resp_data;

  // Under contention the port that did not win last time goes first.
  assign o_p0_gnt = ~rst & i_p0_req & (~i_p1_req | last);
  assign o_p1_gnt = ~rst & i_p1_req & (~i_p0_req | ~last);
  assign accept   = o_p0_gnt | o_p1_gnt;
  assign sel      = o_p1_gnt;

  assign s_we    = sel ? i_p1_we    : i_p0_we;
  assign s_size  = sel ? i_p1_size  : i_p0_size;
  assign s_uns   = sel ? i_p1_uns   : i_p0_uns;
  assign s_addr  = sel ? i_p1_addr  : i_p0_addr;
  assign s_wdata = sel ? i_p1_wdata : i_p0_wdata;
  assign s_off   = s_addr[1:0];
  assign s_legal = is_legal(s_size, s_off);

  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_mask = 4'b0000;
    o_mem_addr = 8'd0;
    o_mem_data = 32'd0;
    if (accept) begin
      o_mem_we   = s_we & s_legal;
      o_mem_mask = gen_mask(s_size, s_off);
      o_mem_addr = 8'(s_addr >> 2);
      o_mem_data = s_wdata << {s_off, 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      r_valid <= 1'b0;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_off   <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= accept;
      if (accept) begin
        last   <= sel;
        r_port <= sel;
        r_we   <= s_we;
        r_size <= s_size;
        r_uns  <= s_uns;
        r_off  <= s_off;
        r_err  <= ~s_legal;
      end
    end
  end

  dmem_ld_align u_ld_align (
    .rdata  (i_mem_data),
    .off    (r_off),
    .size   (r_size),
    .uns    (r_uns),
    .result (ld_res)
  );

  // A response still in flight when reset arrives is dropped.
  assign resp      = r_valid & ~rst;
  assign resp_data = (r_we | r_err) ? 32'd0 : ld_res;

  assign o_p0_rvalid = resp & ~r_port;
  assign o_p1_rvalid = resp & r_port;
  assign o_p0_rdata  = o_p0_rvalid ? resp_data : 32'd0;
  assign o_p1_rdata  = o_p1_rvalid ? resp_data : 32'd0;
  assign o_p0_err    = o_p0_rvalid & r_err;
  assign o_p1_err    = o_p1_rvalid & r_err;

endmodule
